// File: rtl/fpmul_arbiter.sv
// fpmul_arbiter: lets NREQ requesters share one combinational half-precision
// multiplier. A round-robin arbiter picks a requester, the product is captured
// in a one-deep result register, and the result goes back to the requester
// that owns it.
//
// Handshakes: a request transfers on a cycle where req_valid_i[k] and
// req_ready_o[k] are both high. A response transfers on a cycle where
// rsp_valid_o[k] and rsp_ready_i[k] are both high. req_ready_o is derived
// combinationally from req_valid_i in the same cycle. A requester must not
// make req_valid_i depend on req_ready_o. rsp_valid_o never depends on
// rsp_ready_i.
//
// Ports:
//   clk_i, rst_i   clock (rising edge) and asynchronous active-high reset
//   req_valid_i    per-requester request valid
//   req_ready_o    one-hot (or zero) grant, high in the accepting cycle
//   opA_i, opB_i   packed 16-bit operands, slice k belongs to requester k
//   tag_i          packed TAGW-bit tags, slice k belongs to requester k
//   rsp_valid_o    one-hot result valid, routed to the result's owner
//   rsp_ready_i    per-requester result accept (non-owner bits ignored)
//   MUL_o, tag_o   held product and its tag
//   inf_o, zero_o, denorm_o  classification of the held product
//   ops_cnt_o      number of drained results, wraps at 16 bits

// fpmul: combinational binary16 multiply with round-to-nearest-even,
// denormal inputs and outputs, overflow to infinity, and a canonical quiet
// NaN (0x7E00) for NaN operands and for infinity times zero.
//
// Ports:
//   opA_i, opB_i   binary16 operands
//   MUL_o          binary16 product
module fpmul (
  input  logic [15:0] opA_i,
  input  logic [15:0] opB_i,
  output logic [15:0] MUL_o
);
  logic               sign;
  logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [10:0]        ma, mb;
  logic [5:0]         ee_sum;
  logic [21:0]        prod, prod_n;
  logic [4:0]         lead;
  logic signed [7:0]  s_raw;
  logic [4:0]         s_c;
  logic               normal;
  logic [33:0]        shifted;
  logic [10:0]        m;
  logic               guard, sticky;
  logic [11:0]        m_r;
  logic [6:0]         e_base;
  logic [16:0]        enc;
  logic [14:0]        mag;

  always_comb begin
    sign   = opA_i[15] ^ opB_i[15];
    a_nan  = (opA_i[14:10] == 5'h1f) && (opA_i[9:0] != 10'd0);
    b_nan  = (opB_i[14:10] == 5'h1f) && (opB_i[9:0] != 10'd0);
    a_inf  = (opA_i[14:10] == 5'h1f) && (opA_i[9:0] == 10'd0);
    b_inf  = (opB_i[14:10] == 5'h1f) && (opB_i[9:0] == 10'd0);
    a_zero = (opA_i[14:0] == 15'd0);
    b_zero = (opB_i[14:0] == 15'd0);

    // Significands with the hidden bit; a denormal uses exponent 1.
    ma = {(opA_i[14:10] != 5'd0), opA_i[9:0]};
    mb = {(opB_i[14:10] != 5'd0), opB_i[9:0]};
    ee_sum = {1'b0, ((opA_i[14:10] == 5'd0) ? 5'd1 : opA_i[14:10])}
           + {1'b0, ((opB_i[14:10] == 5'd0) ? 5'd1 : opB_i[14:10])};

    // Exact product: value = prod * 2^(ee_sum - 50).
    prod = ma * mb;

    lead = 5'd0;
    for (int i = 0; i < 22; i++) begin
      if (prod[i]) lead = i[4:0];
    end
    prod_n = prod << (5'd21 - lead);

    // Right shift of prod_n that lands the result at its output quantum.
    // 11 means a normal result. Larger values mean the result is denormal
    // and is quantised at 2^-24.
    s_raw  = 8'sd47 - $signed({2'b00, ee_sum}) - $signed({3'b000, lead});
    normal = (s_raw <= 8'sd11);
    if (normal)                 s_c = 5'd11;
    else if (s_raw >= 8'sd23)   s_c = 5'd23;
    else                        s_c = s_raw[4:0];

    shifted = 34'({prod_n, 23'b0} >> s_c);
    m       = shifted[33:23];
    guard   = shifted[22];
    sticky  = |shifted[21:0];
    m_r     = {1'b0, m} + {11'b0, guard & (sticky | m[0])};

    // The hidden bit of m_r adds 1 to the exponent field. A rounding carry
    // therefore moves into the exponent field (or promotes a denormal to the
    // smallest normal) without any special case.
    e_base = normal ? ({1'b0, ee_sum} + {2'b00, lead} - 7'd36) : 7'd0;
    enc    = {e_base, 10'b0} + {5'b0, m_r};
    mag    = (enc >= 17'h07C00) ? 15'h7C00 : enc[14:0];

    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) MUL_o = 16'h7E00;
    else if (a_inf || b_inf)                                      MUL_o = {sign, 15'h7C00};
    else if (prod == 22'd0)                                       MUL_o = {sign, 15'h0000};
    else                                                          MUL_o = {sign, mag};
  end
endmodule

module fpmul_arbiter #(
  parameter int NREQ = 2,
  parameter int TAGW = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [16*NREQ-1:0]   opA_i,
  input  logic [16*NREQ-1:0]   opB_i,
  input  logic [TAGW*NREQ-1:0] tag_i,
  output logic [NREQ-1:0]      rsp_valid_o,
  input  logic [NREQ-1:0]      rsp_ready_i,
  output logic [15:0]          MUL_o,
  output logic [TAGW-1:0]      tag_o,
  output logic                 inf_o,
  output logic                 zero_o,
  output logic                 denorm_o,
  output logic [15:0]          ops_cnt_o
);
  localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t          state, state_nxt;
  logic [PTRW-1:0] ptr, own, gnt_idx;
  logic            found, drain, grant;
  logic [15:0]     mux_a, mux_b, prod;
  int              j;

  // Round-robin search: first valid requester at or after ptr, wrapping.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    j       = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req_valid_i[j]) begin
        found   = 1'b1;
        gnt_idx = j[PTRW-1:0];
      end
    end
  end

  // A drain frees the register in the same cycle, so a new grant can load it
  // back-to-back. Grants are suppressed while reset is held, so all outputs
  // stay zero during reset.
  always_comb begin
    drain = (state == FULL) && rsp_ready_i[own];
    grant = !rst_i && found && ((state == EMPTY) || drain);

    req_ready_o = '0;
    if (grant) req_ready_o[gnt_idx] = 1'b1;

    rsp_valid_o = '0;
    if (state == FULL) rsp_valid_o[own] = 1'b1;

    mux_a = opA_i[int'(gnt_idx)*16 +: 16];
    mux_b = opB_i[int'(gnt_idx)*16 +: 16];
  end

  fpmul u_fpmul (
    .opA_i (mux_a),
    .opB_i (mux_b),
    .MUL_o (prod)
  );

  always_comb begin
    state_nxt = state;
    if (grant)      state_nxt = FULL;
    else if (drain) state_nxt = EMPTY;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= EMPTY;
      ptr       <= '0;
      own       <= '0;
      MUL_o     <= '0;
      tag_o     <= '0;
      inf_o     <= 1'b0;
      zero_o    <= 1'b0;
      denorm_o  <= 1'b0;
      ops_cnt_o <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        MUL_o    <= prod;
        tag_o    <= tag_i[int'(gnt_idx)*TAGW +: TAGW];
        inf_o    <= (prod[14:10] == 5'h1f);
        zero_o   <= (prod[14:0] == 15'd0);
        denorm_o <= (prod[14:10] == 5'd0) && (prod[9:0] != 10'd0);
        own      <= gnt_idx;
        ptr      <= (gnt_idx == PTRW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
      if (drain) ops_cnt_o <= ops_cnt_o + 16'd1;
    end
  end
endmodule

// File: tb/tb_fpmul_arbiter.sv
// Bench for fpmul_arbiter: reset state, a table of single multiplies,
// directed arbitration, back-pressure and reset sequences, randomized traffic
// against a behavioural model, and ops counter wrap.
module tb_fpmul_arbiter;
  localparam int NREQ  = 2;
  localparam int TAGW  = 4;
  localparam int NRAND = 400;
  localparam int NV    = 15;

  logic                 clk, rst;
  logic [NREQ-1:0]      req_valid, req_ready_o, rsp_valid_o, rsp_ready;
  logic [16*NREQ-1:0]   op_a, op_b;
  logic [TAGW*NREQ-1:0] tag;
  logic [15:0]          mul_o, ops_cnt_o;
  logic [TAGW-1:0]      tag_o;
  logic                 inf_o, zero_o, denorm_o;

  int n_checks = 0;
  int n_fail   = 0;

  fpmul_arbiter #(.NREQ(NREQ), .TAGW(TAGW)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready_o),
    .opA_i       (op_a),
    .opB_i       (op_b),
    .tag_i       (tag),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready),
    .MUL_o       (mul_o),
    .tag_o       (tag_o),
    .inf_o       (inf_o),
    .zero_o      (zero_o),
    .denorm_o    (denorm_o),
    .ops_cnt_o   (ops_cnt_o)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic real pow2(input int n);
    real r;
    r = 1.0;
    if (n >= 0) for (int k = 0; k < n; k++) r = r * 2.0;
    else        for (int k = 0; k < -n; k++) r = r / 2.0;
    return r;
  endfunction

  // Magnitude of a finite binary16 value.
  function automatic real h2r(input logic [15:0] h);
    int e;
    int f;
    e = int'(h[14:10]);
    f = int'(h[9:0]);
    if (e == 0) return $itor(f) * pow2(-24);
    return $itor(1024 + f) * pow2(e - 25);
  endfunction

  // Non-negative real to binary16 magnitude, round to nearest even.
  function automatic logic [15:0] r2h(input real v);
    real x, q, fl, fr;
    int  e, code;
    if (v == 0.0) return 16'h0000;
    x = v;
    e = 0;
    while (x >= 2.0) begin x = x / 2.0; e++; end
    while (x < 1.0)  begin x = x * 2.0; e--; end
    if (e > 15) return 16'h7C00;
    if (e < -14) q = v * 16777216.0;
    else         q = x * 1024.0;
    fl   = $floor(q);
    fr   = q - fl;
    code = $rtoi(fl);
    if (fr > 0.5 || (fr == 0.5 && (code % 2) == 1)) code++;
    if (e >= -14) code = code + (e + 14) * 1024;
    if (code >= 31744) code = 31744;
    return code[15:0];
  endfunction

  function automatic logic [15:0] fpmul_ref(input logic [15:0] a, input logic [15:0] b);
    logic       s, an, bn, ai, bi, az, bz;
    logic [15:0] r;
    s  = a[15] ^ b[15];
    an = (a[14:10] == 5'h1f) && (a[9:0] != 0);
    bn = (b[14:10] == 5'h1f) && (b[9:0] != 0);
    ai = (a[14:10] == 5'h1f) && (a[9:0] == 0);
    bi = (b[14:10] == 5'h1f) && (b[9:0] == 0);
    az = (a[14:0] == 0);
    bz = (b[14:0] == 0);
    if (an || bn || (ai && bz) || (bi && az)) return 16'h7E00;
    if (ai || bi) return {s, 15'h7C00};
    r = r2h(h2r(a) * h2r(b));
    return {s, r[14:0]};
  endfunction

  logic [15:0] picks [8] = '{16'h0000, 16'h0001, 16'h03FF, 16'h0400,
                             16'h3C00, 16'h7BFF, 16'h7C00, 16'h8001};

  function automatic logic [15:0] rnd_op();
    if ($urandom_range(0, 1) == 1) return 16'($urandom);
    return picks[$urandom_range(0, 7)];
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] a, b;
    logic [3:0]  t;
    logic [15:0] mul;
    logic        inf, zero, den;
  } vec_t;
  vec_t tbl [NV];

  typedef struct {
    logic [15:0] mul;
    logic [3:0]  t;
    int          own;
  } res_t;
  res_t exp_q[$];

  logic [NREQ-1:0] pend, m_ready, m_rsp;
  int              m_ptr, m_cnt, g;
  bit              fnd, drn, got;
  logic [15:0]     em;

  // ---------------- test sequence ----------------
  initial begin
    tbl[0]  = '{16'h4400, 16'h4000, 4'h3, 16'h4800, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{16'h5380, 16'h4F00, 4'hA, 16'h6690, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{16'h7800, 16'h7800, 4'h5, 16'h7C00, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{16'h4200, 16'h0010, 4'h1, 16'h0030, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{16'h4200, 16'h0001, 4'h2, 16'h0003, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{16'h0000, 16'h3C00, 4'h4, 16'h0000, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{16'hBC00, 16'h4000, 4'h6, 16'hC000, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{16'h3C01, 16'h3C01, 4'h7, 16'h3C02, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{16'h0001, 16'h3800, 4'h8, 16'h0000, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{16'h0001, 16'h3A00, 4'h9, 16'h0001, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{16'h0400, 16'h3800, 4'hB, 16'h0200, 1'b0, 1'b0, 1'b1};
    tbl[11] = '{16'h03FF, 16'h3C01, 4'hC, 16'h0400, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{16'h7C00, 16'h0000, 4'hD, 16'h7E00, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{16'h7BFF, 16'h3C00, 4'hE, 16'h7BFF, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{16'h7BFF, 16'h3C01, 4'hF, 16'h7C00, 1'b1, 1'b0, 1'b0};

    // Reset with every request valid: all outputs zero.
    rst       = 1'b1;
    req_valid = '1;
    rsp_ready = '0;
    op_a      = '0;
    op_b      = '0;
    tag       = '0;
    @(negedge clk);
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_mul", mul_o, 0);
    chk("rst_tag", tag_o, 0);
    chk("rst_flags", {inf_o, zero_o, denorm_o}, 0);
    chk("rst_ops_cnt", ops_cnt_o, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("rst_first_grant", req_ready_o, 2'b01);
    req_valid = '0;

    // Single multiplies, alternating requesters.
    for (int i = 0; i < NV; i++) begin
      int r;
      r = i % NREQ;
      @(posedge clk);
      #1;
      op_a[r*16 +: 16]     = tbl[i].a;
      op_b[r*16 +: 16]     = tbl[i].b;
      tag[r*TAGW +: TAGW]  = tbl[i].t;
      req_valid            = '0;
      req_valid[r]         = 1'b1;
      rsp_ready            = '1;
      got = 0;
      for (int c = 0; c < 10 && !got; c++) begin
        @(negedge clk);
        if (req_ready_o[r]) got = 1;
      end
      chk("tbl_grant", got, 1);
      @(posedge clk);
      #1 req_valid = '0;
      @(negedge clk);
      chk("tbl_rsp_valid", rsp_valid_o, 1 << r);
      chk("tbl_mul", mul_o, tbl[i].mul);
      chk("tbl_tag", tag_o, tbl[i].t);
      chk("tbl_flags", {inf_o, zero_o, denorm_o}, {tbl[i].inf, tbl[i].zero, tbl[i].den});
      chk("tbl_ops_cnt", ops_cnt_o, i);
    end
    @(posedge clk);
    @(negedge clk);
    chk("tbl_ops_final", ops_cnt_o, NV);

    // Both requesters valid every cycle: alternating grants, no bubbles.
    do_reset();
    op_a[15:0]  = 16'h4400; op_b[15:0]  = 16'h4000; tag[3:0] = 4'h1;
    op_a[31:16] = 16'h3C00; op_b[31:16] = 16'h4200; tag[7:4] = 4'h2;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("alt_req_ready", req_ready_o, 1 << (k % 2));
      if (k == 0) chk("alt_rsp_valid", rsp_valid_o, 0);
      else begin
        chk("alt_rsp_valid", rsp_valid_o, 1 << ((k - 1) % 2));
        chk("alt_mul", mul_o, ((k - 1) % 2 == 0) ? 16'h4800 : 16'h4200);
      end
    end

    // Back-pressure on requester 1 while requester 0 waits.
    do_reset();
    op_a[31:16] = 16'h7800; op_b[31:16] = 16'h7800; tag[7:4] = 4'h5;
    op_a[15:0]  = 16'h4400; op_b[15:0]  = 16'h4000; tag[3:0] = 4'h9;
    rsp_ready = 2'b01;
    req_valid = 2'b10;
    @(negedge clk);
    chk("bp_grant1", req_ready_o, 2'b10);
    @(posedge clk);
    #1 req_valid = 2'b01;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_stall_ready", req_ready_o, 2'b00);
      chk("bp_rsp_valid", rsp_valid_o, 2'b10);
      chk("bp_mul", mul_o, 16'h7C00);
      chk("bp_tag", tag_o, 4'h5);
      chk("bp_inf", inf_o, 1);
      @(posedge clk);
      #1;
    end
    rsp_ready = 2'b11;
    @(negedge clk);
    chk("bp_release_grant", req_ready_o, 2'b01);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    @(negedge clk);
    chk("bp_next_valid", rsp_valid_o, 2'b01);
    chk("bp_next_mul", mul_o, 16'h4800);
    chk("bp_next_tag", tag_o, 4'h9);
    chk("bp_ops_cnt", ops_cnt_o, 1);

    // Reset pulse while FULL (pointer is 1 at this point).
    #2 rst = 1'b1;
    #1;
    chk("rstfull_rsp_valid", rsp_valid_o, 0);
    chk("rstfull_ops_cnt", ops_cnt_o, 0);
    chk("rstfull_mul", mul_o, 0);
    req_valid = 2'b11;
    #1 chk("rstfull_no_grant", req_ready_o, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("rstfull_ptr0", req_ready_o, 2'b01);

    // Randomized traffic against the model.
    do_reset();
    pend  = '0;
    m_ptr = 0;
    m_cnt = 0;
    exp_q.delete();
    for (int cyc = 0; cyc < NRAND; cyc++) begin
      @(negedge clk);
      drn = (exp_q.size() != 0) && rsp_ready[exp_q[0].own];
      fnd = 0;
      g   = 0;
      if (exp_q.size() == 0 || drn) begin
        for (int i = 0; i < NREQ; i++) begin
          int jj;
          jj = (m_ptr + i) % NREQ;
          if (!fnd && req_valid[jj]) begin
            fnd = 1;
            g   = jj;
          end
        end
      end
      m_ready = '0;
      if (fnd) m_ready[g] = 1'b1;
      m_rsp = '0;
      if (exp_q.size() != 0) m_rsp[exp_q[0].own] = 1'b1;
      chk("rnd_req_ready", req_ready_o, m_ready);
      chk("rnd_rsp_valid", rsp_valid_o, m_rsp);
      chk("rnd_ops_cnt", ops_cnt_o, 16'(m_cnt));
      if (exp_q.size() != 0) begin
        em = exp_q[0].mul;
        chk("rnd_mul", mul_o, em);
        chk("rnd_tag", tag_o, exp_q[0].t);
        chk("rnd_flags", {inf_o, zero_o, denorm_o},
            {em[14:10] == 5'h1f, em[14:0] == 15'd0, (em[14:10] == 5'd0) && (em[9:0] != 10'd0)});
      end
      if (drn) begin
        void'(exp_q.pop_front());
        m_cnt++;
      end
      if (fnd) begin
        exp_q.push_back('{fpmul_ref(op_a[g*16 +: 16], op_b[g*16 +: 16]), tag[g*TAGW +: TAGW], g});
        m_ptr   = (g + 1) % NREQ;
        pend[g] = 1'b0;
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < NREQ; k++) begin
        if (pend[k] && $urandom_range(0, 15) == 0) pend[k] = 1'b0;
        else if (!pend[k] && $urandom_range(0, 2) != 0) begin
          pend[k]                = 1'b1;
          op_a[k*16 +: 16]       = rnd_op();
          op_b[k*16 +: 16]       = rnd_op();
          tag[k*TAGW +: TAGW]    = TAGW'($urandom);
        end
        req_valid[k] = pend[k];
      end
      rsp_ready = NREQ'($urandom);
    end

    // Ops counter wrap: continuous traffic drains once per edge after the first.
    do_reset();
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    repeat (65536) @(posedge clk);
    @(negedge clk);
    chk("cnt_ffff", ops_cnt_o, 16'hFFFF);
    @(posedge clk);
    @(negedge clk);
    chk("cnt_wrap", ops_cnt_o, 16'h0000);
    req_valid = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
